// File: rtl/mau_pkg.sv
// Shared types and default sizes for the memory access unit.
// Contents: request size encoding, FSM state encoding, default address/data
// widths and the read-address bias of the downstream data memory.
package mau_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 6;   // 64 words
  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned RD_BIAS_DEFAULT = 5;   // memory returns rf[rd_addr-5]

  // Encoding 2'd3 is reserved and reported as an error.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian word.
// Ports:
//   old_word  in  32  word currently in memory
//   new_data  in  32  store data, right-aligned
//   lane      in  2   byte offset within the word (addr[1:0])
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sgn       in  1   sign-extend the load result
//   merged    out 32  old_word with the addressed lanes replaced by new_data
//   load_word out 32  addressed lanes of old_word, sign/zero extended
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] merged,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged    = old_word;
    load_word = old_word;
    byte_sel  = old_word[{lane, 3'b000} +: 8];
    half_sel  = old_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = new_data[7:0];
        load_word = {{24{sgn & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        // Halves live in lanes {1,0} or {3,2}; addr[0] was already rejected.
        merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
        load_word = {{16{sgn & half_sel[15]}}, half_sel};
      end
      default: begin
        merged    = new_data;
        load_word = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed data memory.
// Accepts byte/half/word requests over valid/ready, checks alignment and
// range, performs sub-word stores as read-modify-write and returns extended
// load data over a response handshake.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_is_store, req_size, req_signed, req_addr, req_wdata  request fields
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            response payload
//   mem_wr_addr, mem_wr_en, mem_wr_data  memory write port
//   mem_rd_addr, mem_rd_data        memory read port (address biased)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned RD_BIAS = RD_BIAS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [ADDR_W-1:0] Bias = ADDR_W'(RD_BIAS);

  state_e              state_q, state_d;
  logic                store_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic                accept;
  logic                acc_err;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   load_word;

  // Request checks, evaluated on the live request at accept time.
  always_comb begin
    acc_err = (req_addr[31:ADDR_W+2] != '0);
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) acc_err = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
  end

  assign accept = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err)                                state_d = ST_RESP;
          else if (req_is_store && req_size == SZ_WORD) state_d = ST_WRITE;
          else                                        state_d = ST_READ;
        end
      end
      ST_READ:  state_d = store_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q      <= req_is_store;
        size_q       <= req_size;
        signed_q     <= req_signed;
        addr_q       <= req_addr[ADDR_W+1:0];
        wr_data_q    <= req_wdata;
        resp_rdata_q <= '0;
        resp_err_q   <= acc_err;
      end
      if (state_q == ST_READ) begin
        // Loads register the extended result; sub-word stores keep the merged word.
        if (store_q) wr_data_q    <= merged;
        else         resp_rdata_q <= load_word;
      end
    end
  end

  mau_lane_align u_lane_align (
    .old_word  (mem_rd_data),
    .new_data  (wr_data_q),
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .sgn       (signed_q),
    .merged    (merged),
    .load_word (load_word)
  );

  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_wr_addr = addr_q[ADDR_W+1:2];
  assign mem_rd_addr = addr_q[ADDR_W+1:2] + Bias;
  assign mem_wr_data = wr_data_q;
  // Gated by rst so an interrupted request never produces a write pulse.
  assign mem_wr_en   = (state_q == ST_WRITE) && !rst;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end sitting directly upstream of the 64x32 word-addressed data memory in the MIPS datapath. It accepts byte, half and word load/store requests from the execute stage over a valid/ready handshake. It checks alignment and range, and maps byte addresses onto the memory's word ports. Sub-word stores are done as read-modify-write, and load data is returned sign- or zero-extended over a response handshake.

Parameters:
ADDR_W, 6, memory word-index width (64 words)
DATA_W, 32, word width
RD_BIAS, 5, constant added to the word index on mem_rd_addr; the data memory returns rf[rd_addr-5]

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_is_store  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as error)
req_signed  input  1  sign-extend load result
req_addr  input  32  byte address
req_wdata  input  32  store data; the value sits right-aligned in the low bits
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or reserved size
mem_wr_addr  output  6  memory write word index
mem_wr_en  output  1  memory write strobe
mem_wr_data  output  32  memory write data
mem_rd_addr  output  6  memory read address, already biased
mem_rd_data  input  32  memory combinational read data

Behaviour:
- Word index is addr[7:2]. Lanes are little-endian: byte k = bits[8k+7:8k], k = addr[1:0]; a half occupies lanes {2*addr[1]+1, 2*addr[1]}.
- mem_rd_addr = word index + RD_BIAS, 6-bit wrap (index 60 -> 1). mem_wr_addr = word index, unbiased.
- States: IDLE, READ, WRITE, RESP.
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. mem_wr_en=0, and it is forced 0 in any cycle rst is high.
- IDLE: req_ready=1. A request is accepted on req_valid&&req_ready, and op, size, signed, addr and wdata are latched.
- Error check at accept: any of the following sends the unit straight to RESP with resp_err=1, no memory access:
  - size 3
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:8]!=0
- Load: IDLE -> READ, then RESP.
  - In READ, mem_rd_data is captured. The selected lanes are extracted, sign-extended if req_signed (else zero-extended) and registered into resp_rdata.
  - resp_valid asserts 2 cycles after accept.
- Word store: IDLE -> WRITE (mem_wr_en=1 for exactly one cycle, data = wdata) -> RESP. resp_valid asserts 2 cycles after accept.
- Sub-word store: IDLE -> READ -> WRITE -> RESP; resp_valid asserts 3 cycles after accept.
  - READ captures the old word.
  - WRITE writes the old word with the target lanes replaced by wdata[7:0] (byte) or wdata[15:0] (half).
- RESP: resp_valid=1 with resp_rdata/resp_err stable until resp_ready. On the handshake the unit returns to IDLE.
  - The next request is accepted in the following cycle at the earliest; there is no same-cycle turnaround.
- req_ready=0 in every state except IDLE; requests never overlap.
- mem_wr_en asserts only in WRITE and never for errors or loads.
- Reset mid-operation: the request is abandoned. There is no write pulse in or after the reset cycle, and no response is produced.

Decomposition:
- Package mau_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (ST_IDLE, ST_READ, ST_WRITE, ST_RESP)
  - ADDR_W, DATA_W and RD_BIAS defaults
- One combinational sub-module, mau_lane_align, is natural: old word, new data, addr[1:0], size, signed -> merged store word and extended load word.
- The FSM, handshakes and registers stay in mem_access_unit.

Test Plan:
1. Word store 0xDEADBEEF to 0x10, then word load 0x10 -> store: mem_wr_addr=4, mem_wr_en one cycle. Load: mem_rd_addr=9, resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
2. After test 1, byte store 0xA5 to 0x11 -> READ then WRITE with mem_wr_data=0xDEADA5EF, resp 3 cycles after accept. Signed byte load 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
3. Signed half load 0x12 -> 0xFFFFDEAD. Unsigned -> 0x0000DEAD.
4. Word load 0x13, half store 0x11, word load 0x100 -> each gives resp_err=1 one cycle after accept, resp_rdata=0, no mem_wr_en.
5. Backpressure: hold resp_ready=0 for 3 cycles on a load -> resp_valid, resp_rdata and resp_err stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the handshake.
6. Reset during READ of a sub-word store -> next cycle IDLE, resp_valid=0, req_ready=1, mem_wr_en never pulses. A subsequent load of index 60 drives mem_rd_addr=1.
